// File: rtl/qosc_cfg_master_if.sv
// Command / response / register-bus bundle for qosc_cfg_master.
//   master modport: the bus initiator (drives cfg_* pins, accepts commands, returns reads)
//   slave modport : the command source / register side (offers commands, drives cfg_rdata)
// Signals:
//   cmd_valid/cmd_ready/cmd_rnw/cmd_addr/cmd_wdata : command stream into the FIFO
//   rsp_valid/rsp_addr/rsp_rdata                   : one-cycle read response
//   busy                                           : FIFO non-empty or sequencer active
//   cfg_addr/cfg_wdata/cfg_wdata_oe/cfg_strobe     : oscillator register-load pins
//   cfg_rdata                                      : oscillator register read data
interface qosc_cfg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rnw;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [2:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_wdata_oe;
  logic       cfg_strobe;
  logic [7:0] cfg_rdata;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cfg_rdata,
    output cmd_ready, rsp_valid, rsp_addr, rsp_rdata, busy,
           cfg_addr, cfg_wdata, cfg_wdata_oe, cfg_strobe
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cfg_rdata,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_rdata, busy,
           cfg_addr, cfg_wdata, cfg_wdata_oe, cfg_strobe
  );
endinterface

// File: rtl/qosc_cfg_master.sv
// Register-bus initiator for the quadrature oscillator's 3-bit address / 8-bit data load port.
// Commands are queued in a small FIFO and sequenced onto the bus with programmable setup,
// strobe and hold times; reads hold the address for READ_WAIT cycles, then sample cfg_rdata
// and return it as a one-cycle response.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (flushes FIFO, drops in-flight command)
//   bus   : qosc_cfg_master_if.master (command, response, busy and cfg_* pins)
module qosc_cfg_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned READ_WAIT  = 3
) (
  input logic               clk,
  input logic               rst_n,
  qosc_cfg_master_if.master bus
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned Max01 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned Max23 = (HOLD_CYC > READ_WAIT) ? HOLD_CYC : READ_WAIT;
  localparam int unsigned MaxCy = (Max01 > Max23) ? Max01 : Max23;
  // Counter loads N-1 and counts to zero, so it only needs to reach MaxCy-1.
  localparam int unsigned CntW  = (MaxCy > 1) ? $clog2(MaxCy) : 1;

  typedef struct packed {
    logic       rnw;
    logic [2:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRead} state_e;

  // ---------------------------------------------------------------- command FIFO
  cmd_t              mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              ready_en_q;
  logic              push, pop, full;
  cmd_t              head;
  state_e            state_q;

  assign full          = (count_q == (PtrW+1)'(FIFO_DEPTH));
  // ready_en_q keeps cmd_ready low during reset and rises on the first edge after release.
  assign bus.cmd_ready = ready_en_q & ~full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign pop           = (state_q == StIdle) & (count_q != '0);
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{rnw: bus.cmd_rnw, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- bus sequencer
  logic [CntW-1:0] cnt_q;
  logic [2:0]      cfg_addr_q;
  logic [7:0]      cfg_wdata_q;
  logic            cfg_oe_q, cfg_strobe_q;
  logic            rsp_valid_q;
  logic [2:0]      rsp_addr_q;
  logic [7:0]      rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cfg_addr_q   <= '0;
      cfg_wdata_q  <= '0;
      cfg_oe_q     <= 1'b0;
      cfg_strobe_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cfg_oe_q     <= 1'b0;
          cfg_strobe_q <= 1'b0;
          if (pop) begin
            cfg_addr_q <= head.addr;
            if (head.rnw) begin
              state_q <= StRead;
              cnt_q   <= CntW'(READ_WAIT - 1);
            end else begin
              cfg_wdata_q <= head.wdata;
              cfg_oe_q    <= 1'b1;
              state_q     <= StSetup;
              cnt_q       <= CntW'(SETUP_CYC - 1);
            end
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q      <= StStrobe;
            cfg_strobe_q <= 1'b1;
            cnt_q        <= CntW'(STROBE_CYC - 1);
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStrobe: begin
          if (cnt_q == '0) begin
            state_q      <= StHold;
            cfg_strobe_q <= 1'b0;
            cnt_q        <= CntW'(HOLD_CYC - 1);
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q  <= StIdle;
            cfg_oe_q <= 1'b0;  // turnaround: data bus released in the IDLE cycle
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StRead: begin
          if (cnt_q == '0) begin
            state_q     <= StIdle;
            rsp_rdata_q <= bus.cfg_rdata;
            rsp_addr_q  <= cfg_addr_q;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q      <= StIdle;
          cfg_oe_q     <= 1'b0;
          cfg_strobe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_addr     = cfg_addr_q;
  assign bus.cfg_wdata    = cfg_wdata_q;
  assign bus.cfg_wdata_oe = cfg_oe_q;
  assign bus.cfg_strobe   = cfg_strobe_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.busy         = (count_q != '0) | (state_q != StIdle);

endmodule
